// File: rtl/ram16k_arbiter_pkg.sv
// Shared types for the ram16k arbiter: RAM geometry, owner state, port id and request bundle.
package ram_pkg;
  localparam int RAM_ADDR_W = 14;
  localparam int RAM_DATA_W = 16;

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} own_t;
  typedef logic port_t;

  typedef struct packed {
    logic                  we;
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_DATA_W-1:0] wdata;
  } req_t;

  function automatic own_t own_of(port_t p);
    return p ? OWN1 : OWN0;
  endfunction
endpackage

// File: rtl/ram16k_arbiter_if.sv
// One requester port of the ram16k arbiter; master = requester, slave = arbiter.
interface ram16k_arbiter_if;
  logic                           req;
  logic                           we;
  logic [ram_pkg::RAM_ADDR_W-1:0] addr;
  logic [ram_pkg::RAM_DATA_W-1:0] wdata;
  logic                           gnt;
  logic                           rvalid;
  logic [ram_pkg::RAM_DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram16k_arbiter_select.sv
// Combinational winner selection. RAM_ARB_RR_EN: burst-limited fair arbitration,
// otherwise strict priority to port 0.
module ram_arb_select
  import ram_pkg::*;
`ifdef RAM_ARB_RR_EN
#(
  parameter int BURST = 4
)
(
  input  own_t       state,
  input  logic [3:0] cnt,
  input  port_t      last,
  input  logic [1:0] req,
  output logic       vld,
  output port_t      sel
);
  localparam logic [3:0] BURST_C = 4'(BURST);

  port_t own;
  assign own = (state == OWN1);

  // A single requester always wins; a tie goes away from the owner once its burst is used up.
  always_comb begin
    vld = |req;
    sel = req[1];
    if (req == 2'b11) begin
      if (state == IDLE) sel = ~last;
      else               sel = (cnt >= BURST_C) ? ~own : own;
    end
  end
`else
(
  input  logic [1:0] req,
  output logic       vld,
  output port_t      sel
);
  assign vld = |req;
  assign sel = ~req[0];
`endif
endmodule

// File: rtl/ram16k_arbiter.sv
// Shares the single-port ram16k between two requesters; read data returns one cycle after grant.
// RAM_ARB_RR_EN selects burst-limited fair arbitration (default build: strict port-0 priority).
module ram16k_arbiter
  import ram_pkg::*;
#(
  parameter int BURST = 4
)
(
  input  logic                  clk,
  input  logic                  reset,
  ram16k_arbiter_if.slave       p0,
  ram16k_arbiter_if.slave       p1,
  output logic [RAM_ADDR_W-1:0] ram_address,
  output logic [RAM_DATA_W-1:0] ram_in_value,
  output logic                  ram_load,
  input  logic [RAM_DATA_W-1:0] ram_out
);
  if (BURST < 1 || BURST > 15) begin : g_burst_chk
    $error("ram16k_arbiter: BURST must be 1..15");
  end

  logic [1:0]       req;
  req_t [1:0]       rq;
  own_t             state;
  logic             vld;
  port_t            sel;
  logic             win_vld;
  req_t             win;
  logic [1:0]       gnt;

  assign req   = {p1.req, p0.req};
  assign rq[0] = {p0.we, p0.addr, p0.wdata};
  assign rq[1] = {p1.we, p1.addr, p1.wdata};

  // Grants and RAM drive are forced low for as long as reset is held.
  assign win_vld = vld & ~reset;
  assign win     = rq[sel];
  assign gnt     = {2{win_vld}} & (sel ? 2'b10 : 2'b01);

  assign p0.gnt       = gnt[0];
  assign p1.gnt       = gnt[1];
  assign ram_address  = win_vld ? win.addr  : '0;
  assign ram_in_value = win_vld ? win.wdata : '0;
  assign ram_load     = win_vld & win.we;
  assign p0.rdata     = ram_out;
  assign p1.rdata     = ram_out;

`ifdef RAM_ARB_RR_EN
  localparam logic [3:0] BURST_C = 4'(BURST);

  logic [3:0] cnt;
  port_t      last;
  logic [1:0] rv;

  ram_arb_select #(.BURST(BURST)) u_sel (
    .state (state),
    .cnt   (cnt),
    .last  (last),
    .req   (req),
    .vld   (vld),
    .sel   (sel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
      rv    <= '0;
    end else begin
      rv <= gnt & {2{~win.we}};
      if (win_vld) begin
        state <= own_of(sel);
        last  <= sel;
        cnt   <= (state == own_of(sel)) ? ((cnt >= BURST_C) ? BURST_C : cnt + 4'd1) : 4'd1;
      end else begin
        state <= IDLE;
        cnt   <= '0;
      end
    end
  end

  assign p0.rvalid = rv[0];
  assign p1.rvalid = rv[1];
`else
  logic rd;

  ram_arb_select u_sel (
    .req (req),
    .vld (vld),
    .sel (sel)
  );

  // Owner state tags the single pending read with the port it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rd    <= 1'b0;
    end else begin
      state <= win_vld ? own_of(sel) : IDLE;
      rd    <= win_vld & ~win.we;
    end
  end

  assign p0.rvalid = rd & (state == OWN0);
  assign p1.rvalid = rd & (state == OWN1);
`endif
endmodule

// File: tb/tb_ram16k_arbiter.sv
// Self-checking bench for ram16k_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a grant-history model and a shadow memory.
`timescale 1ns/1ps
module tb_ram16k_arbiter;
  import ram_pkg::*;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ram16k_arbiter_if p0_if();
  ram16k_arbiter_if p1_if();
  logic [13:0] ram_address;
  logic [15:0] ram_in_value;
  logic        ram_load;
  logic [15:0] ram_out;

  ram16k_arbiter #(.BURST(BURST)) dut (
    .clk          (clk),
    .reset        (reset),
    .p0           (p0_if),
    .p1           (p1_if),
    .ram_address  (ram_address),
    .ram_in_value (ram_in_value),
    .ram_load     (ram_load),
    .ram_out      (ram_out)
  );

  // Behavioural ram16k: registered read, write visible to a read on the next cycle.
  logic [15:0] ram_mem [0:16383];
  logic        ram_clr = 1'b1;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 16384; i++) ram_mem[i] <= '0;
      ram_out <= '0;
    end else begin
      if (ram_load) ram_mem[ram_address] <= ram_in_value;
      ram_out <= ram_load ? ram_in_value : ram_mem[ram_address];
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] gnts();
    return {p1_if.gnt, p0_if.gnt};
  endfunction

  function automatic logic [1:0] rvs();
    return {p1_if.rvalid, p0_if.rvalid};
  endfunction

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [13:0] a, input logic [15:0] d);
    if (p == 0) begin
      p0_if.req = r; p0_if.we = w; p0_if.addr = a; p0_if.wdata = d;
    end else begin
      p1_if.req = r; p1_if.we = w; p1_if.addr = a; p1_if.wdata = d;
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Model state: previous cycle's winner (-1 = none), run length of that winner,
  // last port ever granted, and the read response owed for the next cycle.
  int          m_prev   = -1;
  int          m_streak = 0;
  int          m_last   = 1;
  logic [1:0]  m_rv     = 2'b00;
  logic [15:0] m_rd [2];
  logic [15:0] shadow [0:16383];
  bit          chk_en   = 0;

  function automatic int expect_sel(logic r0, logic r1);
    if (!r0 && !r1) return -1;
    if (r0 != r1)   return r0 ? 0 : 1;
`ifdef RAM_ARB_RR_EN
    if (m_prev < 0) return 1 - m_last;
    return (m_streak >= BURST) ? 1 - m_prev : m_prev;
`else
    return 0;
`endif
  endfunction

  always @(posedge reset) begin
    m_prev = -1; m_streak = 0; m_last = 1; m_rv = 2'b00;
  end

  int          e;
  logic        ewe;
  logic [13:0] ea;
  logic [15:0] ed;
  always @(negedge clk) if (chk_en) begin
    if (reset) begin
      chk("rst_gnt", gnts(), 2'b00);
      chk("rst_load", ram_load, 1'b0);
      chk("rst_addr", ram_address, 14'h0);
      chk("rst_rvalid", rvs(), 2'b00);
      m_prev = -1; m_streak = 0; m_last = 1; m_rv = 2'b00;
    end else begin
      e = expect_sel(p0_if.req, p1_if.req);
      if (e == 0)      begin ewe = p0_if.we; ea = p0_if.addr; ed = p0_if.wdata; end
      else if (e == 1) begin ewe = p1_if.we; ea = p1_if.addr; ed = p1_if.wdata; end
      else             begin ewe = 1'b0;     ea = '0;         ed = '0;          end
      chk("gnt", gnts(), (e < 0) ? 2'b00 : ((e == 0) ? 2'b01 : 2'b10));
      chk("ram_address", ram_address, ea);
      chk("ram_in_value", ram_in_value, ed);
      chk("ram_load", ram_load, ewe);
      chk("rvalid", rvs(), m_rv);
      if (m_rv[0]) chk("p0_rdata", p0_if.rdata, m_rd[0]);
      if (m_rv[1]) chk("p1_rdata", p1_if.rdata, m_rd[1]);
      m_rv = 2'b00;
      if (e >= 0) begin
        m_streak = (e == m_prev) ? m_streak + 1 : 1;
        m_prev   = e;
        m_last   = e;
        if (ewe) shadow[ea] = ed;
        else begin m_rv[e] = 1'b1; m_rd[e] = shadow[ea]; end
      end else begin
        m_prev = -1; m_streak = 0;
      end
    end
  end

  function automatic logic [1:0] t3_exp(int i);
`ifdef RAM_ARB_RR_EN
    return ((i / 4) % 2 == 1) ? 2'b10 : 2'b01;
`else
    return 2'b01;
`endif
  endfunction

  logic [1:0] t4 [7];
  logic [1:0] g;
  int         hp;

  initial begin
    for (int i = 0; i < 16384; i++) shadow[i] = '0;
`ifdef RAM_ARB_RR_EN
    t4 = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
`else
    t4 = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
`endif
    drive(0, 1'b1, 1'b0, 14'h001, 16'h0);
    drive(1, 1'b1, 1'b0, 14'h002, 16'h0);
    chk_en = 1;

    // 1: reset held with both requesting, then release
    @(posedge clk); #1; ram_clr = 1'b0;
    repeat (2) cyc();
    #1;
    chk("t1_gnt_in_rst", gnts(), 2'b00);
    chk("t1_load_in_rst", ram_load, 1'b0);
    chk("t1_rv_in_rst", rvs(), 2'b00);
    reset = 1'b0;
    #1;
    chk("t1_first_gnt", gnts(), 2'b01);
    cyc();

    // 2: p0 writes 0xBEEF to 0x0010, p1 reads it back
    drive(0, 1'b1, 1'b1, 14'h0010, 16'hBEEF);
    drive(1, 1'b0, 1'b0, 14'h0, 16'h0);
    #1;
    chk("t2_wr_gnt", gnts(), 2'b01);
    chk("t2_wr_load", ram_load, 1'b1);
    chk("t2_wr_addr", ram_address, 14'h0010);
    cyc();
    drive(0, 1'b0, 1'b0, 14'h0, 16'h0);
    drive(1, 1'b1, 1'b0, 14'h0010, 16'h0);
    #1;
    chk("t2_rd_gnt", gnts(), 2'b10);
    chk("t2_no_wr_resp", rvs(), 2'b00);
    cyc();
    drive(1, 1'b0, 1'b0, 14'h0, 16'h0);
    #1;
    chk("t2_rvalid", rvs(), 2'b10);
    chk("t2_rdata", p1_if.rdata, 16'hBEEF);
    cyc();

    // 3: both ports read continuously
    drive(0, 1'b1, 1'b0, 14'h0020, 16'h0);
    drive(1, 1'b1, 1'b0, 14'h0030, 16'h0);
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("t3_gnt", gnts(), t3_exp(i));
      if (i > 0) chk("t3_rv", rvs(), t3_exp(i - 1));
      cyc();
    end
    drive(0, 1'b0, 1'b0, 14'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 14'h0, 16'h0);
    #1;
    chk("t3_rv_last", rvs(), t3_exp(11));
    cyc();

    // 4: p0 for two cycles, drops while p1 waits, then p1 keeps its fresh burst
    for (int j = 0; j < 7; j++) begin
      if (j == 0) begin drive(0, 1'b1, 1'b0, 14'h0040, 16'h0); drive(1, 1'b0, 1'b0, 14'h0, 16'h0); end
      if (j == 1) drive(1, 1'b1, 1'b0, 14'h0041, 16'h0);
      if (j == 2) drive(0, 1'b0, 1'b0, 14'h0, 16'h0);
      if (j == 3) drive(0, 1'b1, 1'b0, 14'h0042, 16'h0);
      #1;
      chk("t4_gnt", gnts(), t4[j]);
      cyc();
    end
    drive(0, 1'b0, 1'b0, 14'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 14'h0, 16'h0);
    cyc();

    // 5: asynchronous reset after a p1 read grant, before the next edge
    drive(1, 1'b1, 1'b0, 14'h0050, 16'h0);
    #1;
    chk("t5_gnt_a", gnts(), 2'b10);
    cyc();
    #1;
    chk("t5_gnt_b", gnts(), 2'b10);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("t5_gnt_in_rst", gnts(), 2'b00);
    chk("t5_load_in_rst", ram_load, 1'b0);
    chk("t5_rv_async_clr", rvs(), 2'b00);
    @(posedge clk); #2;
    chk("t5_no_rvalid", rvs(), 2'b00);
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 14'h0051, 16'h0);
    #1;
    chk("t5_idle_tie", gnts(), 2'b01);
    cyc();
    drive(0, 1'b0, 1'b0, 14'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 14'h0, 16'h0);
    #1;
    chk("t5_rv_after", rvs(), 2'b01);
    cyc();

    // 6: priority behaviour, and p1 granted at once when p0 is idle
`ifndef RAM_ARB_RR_EN
    drive(0, 1'b1, 1'b0, 14'h0060, 16'h0);
    drive(1, 1'b1, 1'b1, 14'h0061, 16'h1234);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("t6_p0_prio", gnts(), 2'b01);
      cyc();
    end
`endif
    drive(0, 1'b0, 1'b0, 14'h0, 16'h0);
    drive(1, 1'b1, 1'b1, 14'h0061, 16'h1234);
    #1;
    chk("t6_p1_when_p0_idle", gnts(), 2'b10);
    chk("t6_p1_load", ram_load, 1'b1);
    cyc();
    drive(1, 1'b0, 1'b0, 14'h0, 16'h0);
    cyc();

    // Randomized traffic: requests are held until granted, occasionally abandoned.
    g = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      hp = (c < 1500) ? 85 : 45;
      for (int p = 0; p < 2; p++) begin
        if (g[p] || !((p == 0) ? p0_if.req : p1_if.req)) begin
          drive(p, ($urandom_range(0, 99) < hp), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 9) == 0) ? 14'($urandom_range(0, 16383)) : 14'($urandom_range(0, 15)),
                16'($urandom));
        end else if ($urandom_range(0, 99) < 5) begin
          drive(p, 1'b0, 1'b0, 14'h0, 16'h0);
        end
      end
      #3;
      g = gnts();
      cyc();
    end
    drive(0, 1'b0, 1'b0, 14'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 14'h0, 16'h0);
    cyc();
    cyc();
    chk_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
